// File: rtl/nibble_exec_unit.sv
// Decode/execute stage of the 4-bit nibble processor: fetch/exec/halt sequencing,
// accumulator and flags, output port latch, and PC control for the upstream stage.
module nibble_exec_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  INS,
    input  logic [3:0]  OPRN,
    input  logic [3:0]  DIN,
    output logic        ENF,
    output logic        ENC,
    output logic        NBL,
    output logic [11:0] LOADC,
    output logic        PHASE,
    output logic [3:0]  ACCU,
    output logic        C,
    output logic        Z,
    output logic [3:0]  DOUT,
    output logic        OSTB,
    output logic        HALTED
);

    localparam int unsigned NW = 4;

    localparam logic [NW-1:0] OP_LIT = 4'h1;
    localparam logic [NW-1:0] OP_ADD = 4'h2;
    localparam logic [NW-1:0] OP_SUB = 4'h3;
    localparam logic [NW-1:0] OP_AND = 4'h4;
    localparam logic [NW-1:0] OP_OR  = 4'h5;
    localparam logic [NW-1:0] OP_XOR = 4'h6;
    localparam logic [NW-1:0] OP_CMP = 4'h7;
    localparam logic [NW-1:0] OP_IN  = 4'h8;
    localparam logic [NW-1:0] OP_OUT = 4'h9;
    localparam logic [NW-1:0] OP_JC  = 4'hA;
    localparam logic [NW-1:0] OP_JZ  = 4'hB;
    localparam logic [NW-1:0] OP_JMP = 4'hC;
    localparam logic [NW-1:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [NW-1:0] acc_nxt, dout_nxt;
    logic          c_nxt, z_nxt, taken;
    logic [NW:0]   sum, diff;

    // 5-bit forms give carry (sum) and borrow (diff) in the top bit
    assign sum   = {1'b0, ACCU} + {1'b0, OPRN};
    assign diff  = {1'b0, ACCU} - {1'b0, OPRN};
    assign LOADC = {4'b0000, ACCU, OPRN};
    assign PHASE = (state != S_FETCH);
    assign HALTED = (state == S_HALT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ENF       = 1'b0;
        ENC       = 1'b0;
        NBL       = 1'b0;
        OSTB      = 1'b0;
        taken     = 1'b0;
        acc_nxt   = ACCU;
        c_nxt     = C;
        z_nxt     = Z;
        dout_nxt  = DOUT;
        case (state)
            S_FETCH: begin
                ENF       = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = (INS == OP_HLT) ? S_HALT : S_FETCH;
                case (INS)
                    OP_LIT: begin acc_nxt = OPRN;              z_nxt = (OPRN == 4'h0); end
                    OP_ADD: begin acc_nxt = sum[NW-1:0];       c_nxt = sum[NW];
                                  z_nxt = (sum[NW-1:0] == 4'h0); end
                    OP_SUB: begin acc_nxt = diff[NW-1:0];      c_nxt = diff[NW];
                                  z_nxt = (diff[NW-1:0] == 4'h0); end
                    OP_AND: begin acc_nxt = ACCU & OPRN;       z_nxt = ((ACCU & OPRN) == 4'h0); end
                    OP_OR:  begin acc_nxt = ACCU | OPRN;       z_nxt = ((ACCU | OPRN) == 4'h0); end
                    OP_XOR: begin acc_nxt = ACCU ^ OPRN;       z_nxt = ((ACCU ^ OPRN) == 4'h0); end
                    OP_CMP: begin c_nxt = diff[NW];            z_nxt = (diff[NW-1:0] == 4'h0); end
                    OP_IN:  begin acc_nxt = DIN;               z_nxt = (DIN == 4'h0); end
                    OP_OUT: begin dout_nxt = ACCU;             OSTB = 1'b1; end
                    OP_JC:  taken = C;
                    OP_JZ:  taken = Z;
                    OP_JMP: taken = 1'b1;
                    default: ;
                endcase
                NBL = taken;
                ENC = ~taken;
            end
            S_HALT: ;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Next-state values equal current ones outside EXEC, so HALT freezes everything
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ACCU <= 4'h0;
            C    <= 1'b0;
            Z    <= 1'b0;
            DOUT <= 4'h0;
        end else begin
            ACCU <= acc_nxt;
            C    <= c_nxt;
            Z    <= z_nxt;
            DOUT <= dout_nxt;
        end
    end

endmodule

// File: tb/tb_nibble_exec_unit.sv
// Directed bench for nibble_exec_unit: a reference model pushes expected values
// into a scoreboard queue, popped and compared when the DUT output is sampled.
module tb_nibble_exec_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  INS = 4'h0, OPRN = 4'h0, DIN = 4'h0;
    logic        ENF, ENC, NBL, PHASE, C, Z, OSTB, HALTED;
    logic [11:0] LOADC;
    logic [3:0]  ACCU, DOUT;

    nibble_exec_unit dut (
        .CLK(CLK), .RESET(RESET), .INS(INS), .OPRN(OPRN), .DIN(DIN),
        .ENF(ENF), .ENC(ENC), .NBL(NBL), .LOADC(LOADC), .PHASE(PHASE),
        .ACCU(ACCU), .C(C), .Z(Z), .DOUT(DOUT), .OSTB(OSTB), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } sb_t;

    sb_t        sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] m_a = 4'h0, m_dout = 4'h0;
    logic       m_c = 1'b0, m_z = 1'b0;

    task automatic push(input string tag, input logic [11:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [11:0] obs);
        sb_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk_ctrl(input string pfx, input bit ph, input bit enf, input bit enc, input bit nbl);
        push({pfx, "_phase"}, 12'(ph));
        push({pfx, "_enf"},   12'(enf));
        push({pfx, "_enc"},   12'(enc));
        push({pfx, "_nbl"},   12'(nbl));
        pop_cmp(12'(PHASE));
        pop_cmp(12'(ENF));
        pop_cmp(12'(ENC));
        pop_cmp(12'(NBL));
    endtask

    task automatic chk_regs(input string pfx, input bit halted);
        push({pfx, "_accu"},   12'(m_a));
        push({pfx, "_c"},      12'(m_c));
        push({pfx, "_z"},      12'(m_z));
        push({pfx, "_dout"},   12'(m_dout));
        push({pfx, "_halted"}, 12'(halted));
        push({pfx, "_phase"},  12'(halted));
        push({pfx, "_ostb"},   12'h000);
        pop_cmp(12'(ACCU));
        pop_cmp(12'(C));
        pop_cmp(12'(Z));
        pop_cmp(12'(DOUT));
        pop_cmp(12'(HALTED));
        pop_cmp(12'(PHASE));
        pop_cmp(12'(OSTB));
    endtask

    task automatic model_exec(input logic [3:0] ins, input logic [3:0] x);
        logic [4:0] s;
        case (ins)
            4'h1: begin m_a = x; m_z = (x == 4'h0); end
            4'h2: begin s = 5'(m_a) + 5'(x); m_a = s[3:0]; m_c = s[4]; m_z = (s[3:0] == 4'h0); end
            4'h3: begin m_c = (m_a < x); m_a = m_a - x; m_z = (m_a == 4'h0); end
            4'h4: begin m_a = m_a & x; m_z = (m_a == 4'h0); end
            4'h5: begin m_a = m_a | x; m_z = (m_a == 4'h0); end
            4'h6: begin m_a = m_a ^ x; m_z = (m_a == 4'h0); end
            4'h7: begin m_c = (m_a < x); m_z = (m_a == x); end
            4'h8: begin m_a = DIN; m_z = (DIN == 4'h0); end
            4'h9: m_dout = m_a;
            default: ;
        endcase
    endtask

    // Entered at a FETCH-cycle negedge; leaves at the following FETCH (or HALT) negedge
    task automatic step(input logic [3:0] ins, input logic [3:0] x);
        bit taken;
        INS  = ins;
        OPRN = x;
        chk_ctrl("fetch", 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        taken = (ins == 4'hA) ? m_c : (ins == 4'hB) ? m_z : (ins == 4'hC);
        push("exec_loadc", {4'h0, m_a, x});
        push("exec_ostb", 12'(ins == 4'h9));
        pop_cmp(LOADC);
        pop_cmp(12'(OSTB));
        chk_ctrl("exec", 1'b1, 1'b0, !taken, taken);
        model_exec(ins, x);
        @(posedge CLK);
        @(negedge CLK);
        chk_regs("post", ins == 4'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_regs("reset", 1'b0);
        chk_ctrl("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;

        // free-run with NOPs: PHASE alternates, ENF only in FETCH
        for (int i = 0; i < 6; i++) begin
            chk_ctrl("freerun", i[0], !i[0], i[0], 1'b0);
            push("freerun_accu", 12'h000);
            pop_cmp(12'(ACCU));
            @(negedge CLK);
        end

        step(4'h1, 4'h9);
        step(4'h2, 4'h8);
        step(4'h2, 4'hF);
        step(4'h1, 4'h3);
        step(4'h7, 4'h5);
        step(4'hA, 4'h7);
        step(4'hB, 4'h4);
        step(4'h1, 4'hA);
        step(4'hC, 4'h2);
        DIN = 4'h6;
        step(4'h8, 4'h0);
        step(4'h9, 4'h0);
        step(4'h6, 4'h6);
        step(4'hB, 4'h5);
        step(4'h1, 4'h0);
        step(4'h3, 4'h1);
        step(4'hA, 4'h3);
        step(4'h4, 4'h9);
        step(4'h5, 4'h2);
        step(4'hD, 4'h1);
        step(4'hF, 4'h0);

        // HALT holds regardless of INS
        for (int i = 0; i < 10; i++) begin
            INS  = 4'h2;
            OPRN = 4'h1;
            chk_ctrl("halt", 1'b1, 1'b0, 1'b0, 1'b0);
            chk_regs("halt", 1'b1);
            @(negedge CLK);
        end

        RESET = 1'b1;
        m_a = 4'h0; m_c = 1'b0; m_z = 1'b0; m_dout = 4'h0;
        #1;
        chk_regs("halt_reset", 1'b0);
        @(negedge CLK);
        RESET = 1'b0;

        step(4'h1, 4'h5);
        INS  = 4'h2;
        OPRN = 4'h1;
        @(posedge CLK);
        #2 RESET = 1'b1;
        m_a = 4'h0; m_c = 1'b0; m_z = 1'b0; m_dout = 4'h0;
        #1;
        chk_regs("midexec_reset", 1'b0);
        chk_ctrl("midexec_reset", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        step(4'h1, 4'hC);
        step(4'h2, 4'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
